// File: rtl/pitch_tracker_pkg.sv
// Shared constants and types for the pitch tracker and related analysis blocks.
package pitch_tracker_pkg;

  localparam int unsigned SYNTH_WIDTH          = 16;
  localparam int unsigned SYNTH_PHASE_ACC_BITS = 32;

  localparam int unsigned PITCH_MAX_PERIOD  = 1024;
  localparam int unsigned PITCH_PERIOD_BITS = $clog2(PITCH_MAX_PERIOD + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } pitch_state_t;

endpackage

// File: rtl/pitch_tracker_recip_divider.sv
// Sequential reciprocal: quotient = floor(2^N / divisor), one quotient bit per
// cycle over N+1 cycles (restoring division). o_done is high during the final
// iteration; o_quotient is complete from the following cycle until next start.
module recip_divider
  import pitch_tracker_pkg::*;
#(
  parameter int unsigned N  = SYNTH_PHASE_ACC_BITS,
  parameter int unsigned DW = PITCH_PERIOD_BITS
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic [N:0]    o_quotient
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_div;
  logic [DW-1:0] r_rem;
  logic [N:0]    r_quo;
  logic          r_busy;

  logic [DW:0]   w_shift;
  logic [DW:0]   w_sub;
  logic          w_ge;
  logic          w_last;

  // One restoring step: dividend 2^N contributes a single 1 in its top bit.
  always_comb begin
    w_shift = {r_rem, (r_cnt == '0)};
    w_ge    = (w_shift >= {1'b0, r_div});
    w_sub   = w_shift - {1'b0, r_div};
    w_last  = r_busy && (r_cnt == CW'(N));
  end

  // Iteration registers: load on start, then shift in one quotient bit per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_div  <= i_divisor;
      r_rem  <= '0;
      r_quo  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_sub[DW-1:0] : w_shift[DW-1:0];
      r_quo <= {r_quo[N-1:0], w_ge};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = w_last;
  assign o_quotient = r_quo;

endmodule

// File: rtl/pitch_tracker.sv
// Pitch tracker: measures the period between hysteresis-qualified rising zero
// crossings and converts it to a synth phase increment floor(2^N / period).
// Optional macro PITCH_SMOOTH_EN: one-pole average of accepted periods feeds
// the divider instead of the raw period.
module pitch_tracker
  import pitch_tracker_pkg::*;
#(
  parameter int          HYST       = 256,
  parameter int unsigned MIN_PERIOD = 20,
  parameter int unsigned MAX_PERIOD = 1024
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic signed [SYNTH_WIDTH-1:0]   sample_in,
  input  logic                            sample_valid_in,
  output logic [SYNTH_PHASE_ACC_BITS-1:0] phase_incr_out,
  output logic                            phase_incr_valid_out,
  output logic                            voiced_out
);

  localparam int unsigned N  = SYNTH_PHASE_ACC_BITS;
  localparam int unsigned PW = $clog2(MAX_PERIOD + 1);
  localparam logic signed [SYNTH_WIDTH-1:0] NEG_HYST = SYNTH_WIDTH'(-HYST);
  localparam logic signed [SYNTH_WIDTH-1:0] POS_HYST = SYNTH_WIDTH'(HYST);

  pitch_state_t r_state, w_state_nxt;

  logic [PW-1:0] r_cnt;
  logic          r_armed;
  logic          r_have_ref;
  logic          r_kill;

  logic          w_below, w_cross, w_at_max, w_unvoiced, w_accept;
  logic [PW-1:0] w_period;
  logic [PW-1:0] w_divisor;
  logic          w_launch, w_post;
  logic          w_div_busy, w_div_done;
  logic [N:0]    w_quotient;
  logic          w_unused_qmsb;

  // Crossing detection and period bookkeeping for the current sample.
  always_comb begin
    w_below    = sample_valid_in && (sample_in < NEG_HYST);
    w_cross    = sample_valid_in && r_armed && (sample_in >= POS_HYST);
    w_period   = r_cnt + 1'b1;
    w_at_max   = (r_cnt == PW'(MAX_PERIOD));
    w_unvoiced = sample_valid_in && !w_cross && (r_cnt == PW'(MAX_PERIOD - 1));
    w_accept   = w_cross && r_have_ref &&
                 (w_period >= PW'(MIN_PERIOD)) && (w_period < PW'(MAX_PERIOD));
  end

  // Period counter, hysteresis arm flag and reference-crossing flag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_have_ref <= 1'b0;
    end else if (sample_valid_in) begin
      if (w_cross)        r_cnt <= '0;
      else if (!w_at_max) r_cnt <= r_cnt + 1'b1;

      if (w_cross)      r_armed <= 1'b0;
      else if (w_below) r_armed <= 1'b1;

      if (w_cross)         r_have_ref <= 1'b1;
      else if (w_unvoiced) r_have_ref <= 1'b0;
    end
  end

`ifdef PITCH_SMOOTH_EN
  localparam int unsigned AW = PW + 2;

  logic [AW-1:0]        r_avg;
  logic                 r_avg_ok;
  logic signed [AW:0]   w_diff;
  logic [AW-1:0]        w_avg_nxt;
  logic [AW-1:0]        w_avg_rnd;

  // Average in Q.2 fixed point; seeded with the raw period, rounded for the divisor.
  always_comb begin
    w_diff    = $signed({1'b0, w_period, 2'b00}) - $signed({1'b0, r_avg});
    w_avg_nxt = r_avg_ok ? (r_avg + AW'(w_diff >>> 2)) : {w_period, 2'b00};
    w_avg_rnd = w_avg_nxt + AW'(2);
    w_divisor = w_avg_rnd[AW-1:2];
  end

  // Average only advances on measurements that actually reach the divider.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_avg    <= '0;
      r_avg_ok <= 1'b0;
    end else if (w_launch) begin
      r_avg    <= w_avg_nxt;
      r_avg_ok <= 1'b1;
    end else if (w_unvoiced) begin
      r_avg_ok <= 1'b0;
    end
  end
`else
  // Raw period is the divisor.
  always_comb begin
    w_divisor = w_period;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_launch)   w_state_nxt = DIVIDE;
      DIVIDE:  if (w_div_done) w_state_nxt = DONE;
      DONE:                    w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: crossings while not IDLE are dropped.
  always_comb begin
    w_launch = w_accept && (r_state == IDLE) && !w_div_busy;
    w_post   = (r_state == DONE);
  end

  recip_divider #(
    .N  (N),
    .DW (PW)
  ) u_div (
    .i_clk      (clk_in),
    .i_rst_n    (rst_in),
    .i_start    (w_launch),
    .i_divisor  (w_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  // Quotient MSB is zero for any divisor >= 2.
  assign w_unused_qmsb = w_quotient[N];

  // An unvoiced event during an in-flight divide suppresses the voiced flag it would set.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                              r_kill <= 1'b0;
    else if (w_launch)                        r_kill <= 1'b0;
    else if (w_unvoiced && r_state != IDLE)   r_kill <= 1'b1;
  end

  // Output registers: post result in DONE; unvoiced clears voiced but keeps the increment.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      phase_incr_out       <= '0;
      phase_incr_valid_out <= 1'b0;
      voiced_out           <= 1'b0;
    end else begin
      phase_incr_valid_out <= w_post;
      if (w_post) phase_incr_out <= w_quotient[N-1:0];
      if (w_unvoiced)  voiced_out <= 1'b0;
      else if (w_post) voiced_out <= !r_kill;
    end
  end

endmodule

// File: tb/tb_pitch_tracker.sv
// Scoreboard bench for pitch_tracker: stimulus pushes expected increments with
// their due cycle, a monitor pops and compares on every valid pulse.
module tb_pitch_tracker;
  import pitch_tracker_pkg::*;

  localparam int unsigned N   = SYNTH_PHASE_ACC_BITS;
  localparam int unsigned GAP = N + 3;

  logic                          clk_in = 1'b0;
  logic                          rst_in = 1'b0;
  logic signed [SYNTH_WIDTH-1:0] sample_in = '0;
  logic                          sample_valid_in = 1'b0;
  logic [N-1:0]                  phase_incr_out;
  logic                          phase_incr_valid_out;
  logic                          voiced_out;

  pitch_tracker #(
    .HYST       (256),
    .MIN_PERIOD (20),
    .MAX_PERIOD (1024)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .sample_in            (sample_in),
    .sample_valid_in      (sample_valid_in),
    .phase_incr_out       (phase_incr_out),
    .phase_incr_valid_out (phase_incr_valid_out),
    .voiced_out           (voiced_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] incr;
    int unsigned  at;
    logic         voiced;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   noise[6] = '{200, -200, -256, 256, 150, -100};

  localparam logic [N-1:0] INC100 = 32'd42949672;
  localparam logic [N-1:0] INC50  = 32'd85899345;
`ifdef PITCH_SMOOTH_EN
  localparam logic [N-1:0] INC2ND = 32'd34359738;
`else
  localparam logic [N-1:0] INC2ND = 32'd21474836;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (phase_incr_valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=%0d required=none", phase_incr_out);
      end else begin
        e = sb.pop_front();
        chk("pulse_incr", 64'(phase_incr_out), 64'(e.incr));
        chk("pulse_cycle", 64'(cyc), 64'(e.at));
        chk("pulse_voiced", 64'(voiced_out), 64'(e.voiced));
      end
    end
  end

  task automatic send(input int v, input bit push, input logic [N-1:0] incr);
    @(negedge clk_in);
    sample_in       = SYNTH_WIDTH'(v);
    sample_valid_in = 1'b1;
    if (push) sb.push_back('{incr: incr, at: cyc + N + 3, voiced: 1'b1});
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    repeat (GAP - 2) @(negedge clk_in);
  endtask

  task automatic seg(input int v, input int n);
    for (int i = 0; i < n; i++) send(v, 1'b0, '0);
  endtask

  // Square wave ending on a crossing sample; crossings are exactly p samples apart.
  task automatic tone(input int p, input int ncross, input int xval, input bit push,
                      input logic [N-1:0] incr);
    seg(-8000, p / 2);
    send(xval, 1'b0, '0);
    for (int i = 1; i < ncross; i++) begin
      seg(8000, p / 2 - 1);
      seg(-8000, p / 2);
      send(xval, push, incr);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_incr", 64'(phase_incr_out), 64'd0);
    chk("rst_valid", 64'(phase_incr_valid_out), 64'd0);
    chk("rst_voiced", 64'(voiced_out), 64'd0);
    rst_in = 1'b1;

    // Period 100 tone, then silence until unvoiced.
    tone(100, 3, 8000, 1'b1, INC100);
    repeat (3) @(negedge clk_in);
    chk("p100_voiced", 64'(voiced_out), 64'd1);
    chk("p100_incr", 64'(phase_incr_out), 64'(INC100));
    seg(0, 1023);
    chk("silence_1023_voiced", 64'(voiced_out), 64'd1);
    send(0, 1'b0, '0);
    chk("silence_1024_voiced", 64'(voiced_out), 64'd0);
    chk("silence_hold_incr", 64'(phase_incr_out), 64'(INC100));
    seg(0, 76);
    chk("silence_end_voiced", 64'(voiced_out), 64'd0);

    // Sub-hysteresis noise (including exactly -HYST), then period 50 firing at exactly +HYST.
    for (int i = 0; i < 60; i++) send(noise[i % 6], 1'b0, '0);
    chk("noise_voiced", 64'(voiced_out), 64'd0);
    tone(50, 3, 256, 1'b1, INC50);
    repeat (3) @(negedge clk_in);
    chk("p50_voiced", 64'(voiced_out), 64'd1);
    chk("p50_incr", 64'(phase_incr_out), 64'(INC50));

    // Reset 10 cycles into a divide.
    seg(8000, 49);
    seg(-8000, 50);
    @(negedge clk_in);
    sample_in       = 16'sd8000;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    repeat (9) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("abort_incr", 64'(phase_incr_out), 64'd0);
    chk("abort_valid", 64'(phase_incr_valid_out), 64'd0);
    chk("abort_voiced", 64'(voiced_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (40) @(negedge clk_in);
    tone(100, 1, 8000, 1'b0, '0);
    repeat (40) @(negedge clk_in);
    chk("post_rst_voiced", 64'(voiced_out), 64'd0);
    chk("post_rst_incr", 64'(phase_incr_out), 64'd0);

    // Period 10 is below MIN_PERIOD: never measured.
    tone(10, 6, 8000, 1'b0, '0);
    repeat (5) @(negedge clk_in);
    chk("p10_voiced", 64'(voiced_out), 64'd0);
    chk("p10_incr", 64'(phase_incr_out), 64'd0);

    // Period 100 then 200 (smoothed divisor 125 when averaging is built in).
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    tone(100, 2, 8000, 1'b1, INC100);
    seg(8000, 99);
    seg(-8000, 100);
    send(8000, 1'b1, INC2ND);
    repeat (5) @(negedge clk_in);
    chk("second_voiced", 64'(voiced_out), 64'd1);
    chk("second_incr", 64'(phase_incr_out), 64'(INC2ND));

    repeat (5) @(negedge clk_in);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
